// File: rtl/rr_pkg.sv
// -----------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the N-lane register-read stage:
//   - decode payload constants (ALU_NOP, OP_TYPE_NONE) and ENABLE/DISABLE
//   - rr_payload_t : field layout of the per-lane pass-through payload
//   - lane_wins()  : write-port priority check used for regfile commit and
//                    for the optional write-back bypass (RR_WB_BYPASS_EN)
// -----------------------------------------------------------------------------
package rr_pkg;

  // Upper bounds used by lane_wins(); callers zero-extend their vectors.
  localparam int MAX_LANES = 4;
  localparam int MAX_AW    = 8;

  localparam logic [5:0] ALU_NOP      = 6'd0;
  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic       ENABLE       = 1'b1;
  localparam logic       DISABLE      = 1'b0;

  typedef struct packed {
    logic [31:0] imm;
    logic [5:0]  alucode;
    logic [1:0]  op1_type;
    logic [1:0]  op2_type;
    logic        is_load;
    logic        is_store;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [31:0] pre_pc;
    logic [6:0]  opcode;
    logic [2:0]  lane_flags;
  } rr_payload_t;

  localparam int PAYLOAD_W = $bits(rr_payload_t);

  // True when lane i is enabled, targets the non-zero address addr, and no
  // higher-index enabled lane targets the same address.
  function automatic logic lane_wins(
    input int                           i,
    input logic [MAX_AW-1:0]            addr,
    input logic [MAX_LANES-1:0]         en,
    input logic [MAX_LANES*MAX_AW-1:0]  addrs
  );
    logic win_s;
    win_s = en[i] && (addrs[i*MAX_AW +: MAX_AW] == addr) &&
            (addr != {MAX_AW{1'b0}});
    for (int j = 0; j < MAX_LANES; j++) begin
      if ((j > i) && en[j] && (addrs[j*MAX_AW +: MAX_AW] == addr)) begin
        win_s = DISABLE;
      end
    end
    return win_s;
  endfunction

endpackage

// File: rtl/rr_stage_n_if.sv
// -----------------------------------------------------------------------------
// rr_stage_n_if
// Bundle of the register-read stage's handshake, lane and write-back signals.
//   master : decode/execute/write-back side (drives in_*, out_ready, flush, wb_*)
//   slave  : the rr_stage_n view
// -----------------------------------------------------------------------------
interface rr_stage_n_if
  import rr_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int PAY_W = PAYLOAD_W
);
  localparam int AW = $clog2(NREG);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_lane_v;
  logic [LANES*AW-1:0]     in_src1;
  logic [LANES*AW-1:0]     in_src2;
  logic [LANES*AW-1:0]     in_dst;
  logic [LANES-1:0]        in_reg_we;
  logic [LANES*PAY_W-1:0]  in_payload;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_lane_v;
  logic [LANES-1:0]        out_reg_we;
  logic [LANES*AW-1:0]     out_src1;
  logic [LANES*AW-1:0]     out_src2;
  logic [LANES*AW-1:0]     out_dst;
  logic [LANES*PAY_W-1:0]  out_payload;
  logic [LANES*XLEN-1:0]   out_rdata1;
  logic [LANES*XLEN-1:0]   out_rdata2;
  logic [LANES-1:0]        wb_en;
  logic [LANES*AW-1:0]     wb_addr;
  logic [LANES*XLEN-1:0]   wb_data;

  modport master (
    output flush, in_valid, in_lane_v, in_src1, in_src2, in_dst, in_reg_we,
           in_payload, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_lane_v, out_reg_we, out_src1, out_src2,
           out_dst, out_payload, out_rdata1, out_rdata2
  );

  modport slave (
    input  flush, in_valid, in_lane_v, in_src1, in_src2, in_dst, in_reg_we,
           in_payload, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_lane_v, out_reg_we, out_src1, out_src2,
           out_dst, out_payload, out_rdata1, out_rdata2
  );

endinterface

// File: rtl/rr_stage_n_regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Register file with LANES write ports and 2*LANES combinational read ports.
//   clk      : clock (storage has no reset; x0 is forced to read zero)
//   wb_en    : per-lane write enable
//   wb_addr  : per-lane write address (x0 writes ignored)
//   wb_data  : per-lane write data
//   rd_addr  : 2*LANES read addresses
//   rd_data  : 2*LANES read data
// Same-address writes in one cycle resolve to the highest-index lane.
// Optional macro RR_WB_BYPASS_EN: a read of an address being committed this
// cycle returns the winning write data instead of the stored value.
// -----------------------------------------------------------------------------
module regfile_mp
  import rr_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic [LANES-1:0]          wb_en,
  input  logic [LANES*AW-1:0]       wb_addr,
  input  logic [LANES*XLEN-1:0]     wb_data,
  input  logic [2*LANES*AW-1:0]     rd_addr,
  output logic [2*LANES*XLEN-1:0]   rd_data
);

  logic [XLEN-1:0]                 mem_r [NREG];
  logic [MAX_LANES-1:0]            en_ext_s;
  logic [MAX_LANES*MAX_AW-1:0]     addr_ext_s;

  // Widen the write ports to the fixed shape lane_wins() expects.
  always_comb begin
    en_ext_s   = {MAX_LANES{1'b0}};
    addr_ext_s = {(MAX_LANES*MAX_AW){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      en_ext_s[i]                        = wb_en[i];
      addr_ext_s[i*MAX_AW +: MAX_AW]     = MAX_AW'(wb_addr[i*AW +: AW]);
    end
  end

  // Commit only the winning lane per address; x0 never wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_wins(i, addr_ext_s[i*MAX_AW +: MAX_AW], en_ext_s, addr_ext_s)) begin
        mem_r[wb_addr[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // Read ports: x0 reads zero, optional same-cycle forwarding of the winner.
  always_comb begin
    rd_data = {(2*LANES*XLEN){1'b0}};
    for (int k = 0; k < 2*LANES; k++) begin
      logic [AW-1:0]   ra_s;
      logic [XLEN-1:0] stored_s;
      logic [XLEN-1:0] byp_s;
      logic            hit_s;
      ra_s  = rd_addr[k*AW +: AW];
      hit_s = 1'b0;
      byp_s = {XLEN{1'b0}};
      if (ra_s == {AW{1'b0}}) begin
        stored_s = {XLEN{1'b0}};
      end else begin
        stored_s = mem_r[ra_s];
      end
`ifdef RR_WB_BYPASS_EN
      // At most one lane wins a given address, so OR-merging is exact.
      for (int i = 0; i < LANES; i++) begin
        logic win_s;
        win_s = lane_wins(i, MAX_AW'(ra_s), en_ext_s, addr_ext_s);
        hit_s = hit_s | win_s;
        byp_s = byp_s | ({XLEN{win_s}} & wb_data[i*XLEN +: XLEN]);
      end
`endif
      rd_data[k*XLEN +: XLEN] = hit_s ? byp_s : stored_s;
    end
  end

endmodule

// File: rtl/rr_stage_n.sv
// -----------------------------------------------------------------------------
// rr_stage_n
// N-lane register-read pipeline stage between decode and execute.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : rr_stage_n_if.slave -- flush, in_* valid/ready bundle, out_*
//          registered bundle with combinational operands, wb_* write ports
// Registers lane payload and source/destination addresses with a valid/ready
// handshake (1-cycle latency); operands come combinationally from the
// register file addressed by the registered sources.
// Optional macro RR_WB_BYPASS_EN enables write-to-read forwarding.
// -----------------------------------------------------------------------------
module rr_stage_n
  import rr_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int PAY_W = PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst,
  rr_stage_n_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  // Idle lane payload: all-zero fields, i.e. ALU_NOP with no operand types.
  localparam logic [PAY_W-1:0] NOP_LANE = PAY_W'({32'd0, ALU_NOP, OP_TYPE_NONE,
    OP_TYPE_NONE, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 7'd0, 3'd0});

  logic                    valid_r;
  logic [LANES-1:0]        lane_v_r;
  logic [LANES-1:0]        reg_we_r;
  logic [LANES*AW-1:0]     src1_r;
  logic [LANES*AW-1:0]     src2_r;
  logic [LANES*AW-1:0]     dst_r;
  logic [LANES*PAY_W-1:0]  payload_r;
  logic [2*LANES*XLEN-1:0] rd_data_s;
  logic                    in_ready_s;

  assign in_ready_s = !valid_r || bus.out_ready;

  // Stage register: reset, then flush, then transfer / drain / stall-hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= DISABLE;
      lane_v_r  <= {LANES{1'b0}};
      reg_we_r  <= {LANES{1'b0}};
      src1_r    <= {(LANES*AW){1'b0}};
      src2_r    <= {(LANES*AW){1'b0}};
      dst_r     <= {(LANES*AW){1'b0}};
      payload_r <= {LANES{NOP_LANE}};
    end else if (bus.flush) begin
      valid_r   <= DISABLE;
      lane_v_r  <= {LANES{1'b0}};
      reg_we_r  <= {LANES{1'b0}};
      src1_r    <= {(LANES*AW){1'b0}};
      src2_r    <= {(LANES*AW){1'b0}};
      dst_r     <= {(LANES*AW){1'b0}};
      payload_r <= {LANES{NOP_LANE}};
    end else if (bus.in_valid && in_ready_s) begin
      valid_r   <= ENABLE;
      lane_v_r  <= bus.in_lane_v;
      // An invalid lane must never request a write-back downstream.
      reg_we_r  <= bus.in_reg_we & bus.in_lane_v;
      src1_r    <= bus.in_src1;
      src2_r    <= bus.in_src2;
      dst_r     <= bus.in_dst;
      payload_r <= bus.in_payload;
    end else if (in_ready_s) begin
      valid_r   <= DISABLE;
    end else begin
      // Stalled: everything holds.
      valid_r   <= valid_r;
    end
  end

  // Read ports 0..LANES-1 serve src1, LANES..2*LANES-1 serve src2.
  regfile_mp #(
    .LANES (LANES),
    .XLEN  (XLEN),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .rd_addr ({src2_r, src1_r}),
    .rd_data (rd_data_s)
  );

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_r;
  assign bus.out_lane_v  = lane_v_r;
  assign bus.out_reg_we  = reg_we_r;
  assign bus.out_src1    = src1_r;
  assign bus.out_src2    = src2_r;
  assign bus.out_dst     = dst_r;
  assign bus.out_payload = payload_r;
  assign bus.out_rdata1  = rd_data_s[LANES*XLEN-1:0];
  assign bus.out_rdata2  = rd_data_s[2*LANES*XLEN-1:LANES*XLEN];

endmodule

// File: tb/tb_rr_stage_n.sv
// -----------------------------------------------------------------------------
// tb_rr_stage_n
// Self-checking bench for rr_stage_n: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage (register
// array plus expected output bundle). Honours RR_WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_rr_stage_n;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int PAY_W = 121;
  localparam int AW    = $clog2(NREG);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_stage_n_if #(.LANES(LANES), .XLEN(XLEN), .NREG(NREG), .PAY_W(PAY_W)) bus ();

  rr_stage_n #(.LANES(LANES), .XLEN(XLEN), .NREG(NREG), .PAY_W(PAY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [XLEN-1:0]  m_regs  [NREG];
  bit               m_known [NREG];
  bit               m_valid = 1'b0;
  logic [LANES-1:0] m_lane_v = '0;
  logic [LANES-1:0] m_reg_we = '0;
  logic [AW-1:0]    m_src1 [LANES];
  logic [AW-1:0]    m_src2 [LANES];
  logic [AW-1:0]    m_dst  [LANES];
  logic [PAY_W-1:0] m_pay  [LANES];

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*PAY_W-1:0] rand_pay();
    logic [LANES*PAY_W-1:0] r;
    for (int b = 0; b < LANES*PAY_W; b++) r[b] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  // Expected operand for a read address under the current write-back inputs.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, output bit ok);
    ok = 1'b1;
    if (a == 0) return '0;
`ifdef RR_WB_BYPASS_EN
    for (int i = LANES - 1; i >= 0; i--)
      if (bus.wb_en[i] && bus.wb_addr[i*AW +: AW] == a) return bus.wb_data[i*XLEN +: XLEN];
`endif
    ok = m_known[a];
    return m_regs[a];
  endfunction

  task automatic check_outputs();
    bit ok;
    logic [XLEN-1:0] e;
    check_val("out_valid", bus.out_valid, m_valid);
    check_val("in_ready", bus.in_ready, !m_valid || bus.out_ready);
    for (int j = 0; j < LANES; j++) begin
      check_val("lane_v", bus.out_lane_v[j], m_lane_v[j]);
      check_val("reg_we", bus.out_reg_we[j], m_reg_we[j]);
      check_val("src1", bus.out_src1[j*AW +: AW], m_src1[j]);
      check_val("src2", bus.out_src2[j*AW +: AW], m_src2[j]);
      check_val("dst", bus.out_dst[j*AW +: AW], m_dst[j]);
      check_val("payload", bus.out_payload[j*PAY_W +: PAY_W], m_pay[j]);
      e = exp_rd(m_src1[j], ok);
      if (ok) check_val("rdata1", bus.out_rdata1[j*XLEN +: XLEN], e);
      e = exp_rd(m_src2[j], ok);
      if (ok) check_val("rdata2", bus.out_rdata2[j*XLEN +: XLEN], e);
    end
  endtask

  task automatic model_clear();
    m_valid  = 1'b0;
    m_lane_v = '0;
    m_reg_we = '0;
    for (int j = 0; j < LANES; j++) begin
      m_src1[j] = '0; m_src2[j] = '0; m_dst[j] = '0; m_pay[j] = '0;
    end
  endtask

  // Model of one clock edge, using the inputs presented during the cycle.
  task automatic model_edge();
    bit rdy;
    logic [AW-1:0] a;
    rdy = !m_valid || bus.out_ready;
    for (int i = 0; i < LANES; i++) begin   // ascending: later lane overwrites
      a = bus.wb_addr[i*AW +: AW];
      if (bus.wb_en[i] && a != 0) begin
        m_regs[a]  = bus.wb_data[i*XLEN +: XLEN];
        m_known[a] = 1'b1;
      end
    end
    if (!rst || bus.flush) model_clear();
    else if (bus.in_valid && rdy) begin
      m_valid  = 1'b1;
      m_lane_v = bus.in_lane_v;
      m_reg_we = bus.in_reg_we & bus.in_lane_v;
      for (int j = 0; j < LANES; j++) begin
        m_src1[j] = bus.in_src1[j*AW +: AW];
        m_src2[j] = bus.in_src2[j*AW +: AW];
        m_dst[j]  = bus.in_dst[j*AW +: AW];
        m_pay[j]  = bus.in_payload[j*PAY_W +: PAY_W];
      end
    end else if (rdy) m_valid = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_lane_v = '0;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.in_dst = '0; bus.in_reg_we = '0;
    bus.in_payload = '0; bus.out_ready = 1'b1;
    bus.wb_en = '0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  task automatic rand_inputs();
    bus.in_valid  = ($urandom % 4) != 0;
    bus.out_ready = ($urandom % 3) != 0;
    bus.flush     = ($urandom % 20) == 0;
    bus.in_lane_v = LANES'($urandom);
    bus.in_reg_we = LANES'($urandom);
    bus.in_payload = rand_pay();
    bus.wb_en     = LANES'($urandom);
    for (int j = 0; j < LANES; j++) begin
      bus.in_src1[j*AW +: AW] = AW'(($urandom % 2) ? $urandom % 8 : $urandom % NREG);
      bus.in_src2[j*AW +: AW] = AW'(($urandom % 2) ? $urandom % 8 : $urandom % NREG);
      bus.in_dst[j*AW +: AW]  = AW'($urandom % NREG);
      bus.wb_addr[j*AW +: AW] = AW'($urandom % 8);
      bus.wb_data[j*XLEN +: XLEN] = $urandom;
    end
  endtask

  logic [LANES*PAY_W-1:0] p1, p2;
  logic [XLEN-1:0] old9;

  initial begin
    model_clear();
    for (int r = 0; r < NREG; r++) begin m_known[r] = 1'b0; m_regs[r] = '0; end
    clear_inputs();
    bus.out_ready = 1'b0;
    cycle();
    // Reset state
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_payload", bus.out_payload, '0);
    check_val("rst_rdata1_0", bus.out_rdata1[0 +: XLEN], '0);

    // Preload every register while still in reset (storage is not reset).
    for (int k = 0; k < 16; k++) begin
      bus.wb_en = '1;
      bus.wb_addr[0 +: AW]  = AW'(2*k + 1);
      bus.wb_addr[AW +: AW] = AW'(2*k + 2);
      bus.wb_data = {$urandom, $urandom};
      cycle();
    end
    clear_inputs();

    // Release reset, first transfer
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b01; bus.in_src1[0 +: AW] = AW'(5);
    cycle();
    check_val("first_valid", bus.out_valid, 1'b1);
    check_val("first_src1", bus.out_src1[0 +: AW], AW'(5));

    // Same-address write conflict: lane 1 wins
    clear_inputs();
    bus.wb_en = 2'b11;
    bus.wb_addr = {AW'(7), AW'(7)};
    bus.wb_data = {32'h0000_BBBB, 32'h0000_AAAA};
    cycle();
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b01; bus.in_src1[0 +: AW] = AW'(7);
    cycle();
    check_val("conflict_x7", bus.out_rdata1[0 +: XLEN], 32'h0000_BBBB);

    // x0 protection
    clear_inputs();
    bus.wb_en = 2'b01; bus.wb_data[0 +: XLEN] = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b11;
    cycle();
    bus.wb_en = '0;
    #1;
    check_val("x0_read", bus.out_rdata1[0 +: XLEN], '0);
    check_val("x0_read2", bus.out_rdata2[XLEN +: XLEN], '0);

    // Stall: payload held, in_ready low, then new bundle on release
    clear_inputs();
    p1 = rand_pay(); p2 = rand_pay();
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b11; bus.in_payload = p1;
    cycle();
    bus.out_ready = 1'b0; bus.in_payload = p2;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_val("stall_ready", bus.in_ready, 1'b0);
      check_val("stall_pay", bus.out_payload, p1);
      cycle();
    end
    check_val("stall_pay_end", bus.out_payload, p1);
    bus.out_ready = 1'b1;
    cycle();
    check_val("stall_release", bus.out_payload, p2);

    // Flush during stall with an incoming bundle
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b01; bus.in_reg_we = 2'b01;
    bus.in_dst[0 +: AW] = AW'(5);
    cycle();
    bus.out_ready = 1'b0; bus.flush = 1'b1; bus.in_dst[0 +: AW] = AW'(6);
    bus.wb_en = 2'b01; bus.wb_addr[0 +: AW] = AW'(3); bus.wb_data[0 +: XLEN] = 32'h0000_1234;
    cycle();
    check_val("flush_valid", bus.out_valid, 1'b0);
    check_val("flush_reg_we", bus.out_reg_we, '0);
    check_val("flush_dst", bus.out_dst, '0);
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b01; bus.in_src1[0 +: AW] = AW'(3);
    cycle();
    check_val("flush_wb_x3", bus.out_rdata1[0 +: XLEN], 32'h0000_1234);

    // Write-to-read bypass on lane 1 src1 = x9
    clear_inputs();
    bus.in_valid = 1'b1; bus.in_lane_v = 2'b10; bus.in_src1[AW +: AW] = AW'(9);
    cycle();
    old9 = m_regs[9];
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.wb_en = 2'b10; bus.wb_addr[AW +: AW] = AW'(9); bus.wb_data[XLEN +: XLEN] = 32'h0000_CAFE;
    #1;
`ifdef RR_WB_BYPASS_EN
    check_val("bypass_same", bus.out_rdata1[XLEN +: XLEN], 32'h0000_CAFE);
`else
    check_val("bypass_same", bus.out_rdata1[XLEN +: XLEN], old9);
`endif
    cycle();
    bus.wb_en = '0;
    #1;
    check_val("bypass_next", bus.out_rdata1[XLEN +: XLEN], 32'h0000_CAFE);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      cycle();
    end
    clear_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
